// File: rtl/park_pkg.sv
// Shared types and constants for the parking-lot controller.
// Contents: gate FSM state type, default CAPACITY / TIME_MAX, and the
// CAR_W / TIME_W widths that the LCD stage also uses.
package park_pkg;

    localparam int CAR_W        = 4;
    localparam int TIME_W       = 6;
    localparam int DEF_CAPACITY = 9;
    localparam int DEF_TIME_MAX = 59;
    localparam int DEF_DEB      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DETECT = 2'd1,
        PASS   = 2'd2
    } gate_state_t;

endpackage

// File: rtl/park_gate_fsm.sv
// Vehicle sensor front end: 2-flop synchronizer, optional debounce, and
// the IDLE/DETECT/PASS FSM that emits one event per vehicle.
// Optional feature macro: PARK_DEBOUNCE_EN (debounce stage; without it the
// FSM sees the synchronizer output directly).
// Ports:
//   clk, rst   clock, async active-low reset
//   i_power    0 = clear synchronizer, debounce and FSM every cycle
//   i_sns      raw asynchronous sensor, 1 = vehicle present
//   o_evt      1-cycle event while in DETECT
//   o_idle     FSM is in IDLE
//
// state  | meaning
// IDLE   | no vehicle on the loop
// DETECT | vehicle just accepted by the debouncer; issue one event
// PASS   | vehicle still on the loop; wait for it to leave
module park_gate_fsm
    import park_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB
) (
    input  logic clk,
    input  logic rst,
    input  logic i_power,
    input  logic i_sns,
    output logic o_evt,
    output logic o_idle
);

    logic [1:0]  r_sync;
    logic        w_sync;
    logic        w_s;
    gate_state_t r_state;
    gate_state_t w_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_sync <= 2'b00;
        else if (!i_power) r_sync <= 2'b00;
        else               r_sync <= {r_sync[0], i_sns};
    end

    assign w_sync = r_sync[1];

`ifdef PARK_DEBOUNCE_EN
    logic       r_s;
    logic [7:0] r_deb;

    // Down-counter runs only while the synchronized level differs from the
    // accepted level; any return to the accepted level reloads it, so the
    // new level must persist DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s   <= 1'b0;
            r_deb <= 8'(DEB_CYCLES - 1);
        end else if (!i_power || (w_sync == r_s)) begin
            if (!i_power) r_s <= 1'b0;
            r_deb <= 8'(DEB_CYCLES - 1);
        end else if (r_deb == 8'd0) begin
            r_s   <= w_sync;
            r_deb <= 8'(DEB_CYCLES - 1);
        end else begin
            r_deb <= r_deb - 8'd1;
        end
    end

    assign w_s = r_s;
`else
    assign w_s = w_sync;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_state <= IDLE;
        else if (!i_power) r_state <= IDLE;
        else               r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        o_evt  = 1'b0;
        o_idle = 1'b0;
        case (r_state)
            IDLE: begin
                o_idle = 1'b1;
                if (w_s) w_next = DETECT;
            end
            DETECT: begin
                o_evt  = 1'b1;
                w_next = PASS;
            end
            PASS: begin
                if (!w_s) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: rtl/park_occupancy_ctrl.sv
// Parking-lot core controller: occupancy and elapsed-time counters, entry
// barrier request and full / reject indication, fed by two sensor FSMs.
// Optional feature macro: PARK_DEBOUNCE_EN (sensor debounce in park_gate_fsm).
// Ports:
//   clk, rst            clock, async active-low reset
//   tick                1-cycle time-base strobe
//   power               0 = everything cleared and held idle
//   enter_sns/exit_sns  raw loop sensors
//   car[3:0]            occupancy 0..CAPACITY (registered)
//   time_cnt[5:0]       elapsed time 0..TIME_MAX, wraps (registered)
//   gate_open           entry barrier request (registered)
//   full                car == CAPACITY (combinational)
//   reject              1-cycle pulse on refused entry (registered)
module park_occupancy_ctrl
    import park_pkg::*;
#(
    parameter int CAPACITY   = DEF_CAPACITY,
    parameter int DEB_CYCLES = DEF_DEB,
    parameter int TIME_MAX   = DEF_TIME_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              power,
    input  logic              enter_sns,
    input  logic              exit_sns,
    output logic [CAR_W-1:0]  car,
    output logic [TIME_W-1:0] time_cnt,
    output logic              gate_open,
    output logic              full,
    output logic              reject
);

    logic              w_ent_evt, w_ent_idle;
    logic              w_ext_evt, w_ext_idle;
    logic              w_ent_ok, w_ext_ok;
    logic [CAR_W-1:0]  r_car;
    logic [TIME_W-1:0] r_time;
    logic              r_gate, r_reject;

    park_gate_fsm #(.DEB_CYCLES(DEB_CYCLES)) u_entry (
        .clk(clk), .rst(rst), .i_power(power), .i_sns(enter_sns),
        .o_evt(w_ent_evt), .o_idle(w_ent_idle)
    );

    park_gate_fsm #(.DEB_CYCLES(DEB_CYCLES)) u_exit (
        .clk(clk), .rst(rst), .i_power(power), .i_sns(exit_sns),
        .o_evt(w_ext_evt), .o_idle(w_ext_idle)
    );

    assign w_ext_ok = w_ext_evt && (r_car != '0);
    // A same-cycle exit frees a slot, so a full lot still admits the entry.
    assign w_ent_ok = w_ent_evt && ((r_car != CAR_W'(CAPACITY)) || w_ext_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_car    <= '0;
            r_time   <= '0;
            r_gate   <= 1'b0;
            r_reject <= 1'b0;
        end else if (!power) begin
            r_car    <= '0;
            r_time   <= '0;
            r_gate   <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            case ({w_ent_ok, w_ext_ok})
                2'b10:   r_car <= r_car + 1'b1;
                2'b01:   r_car <= r_car - 1'b1;
                default: r_car <= r_car;
            endcase
            if (tick) r_time <= (r_time == TIME_W'(TIME_MAX)) ? '0 : r_time + 1'b1;
            if (w_ent_ok)        r_gate <= 1'b1;
            else if (w_ent_idle) r_gate <= 1'b0;
            r_reject <= w_ent_evt && !w_ent_ok;
        end
    end

    assign car       = r_car;
    assign time_cnt  = r_time;
    assign gate_open = r_gate;
    assign reject    = r_reject;
    assign full      = (r_car == CAR_W'(CAPACITY));

endmodule
